// File: rtl/fetch_cache_unit_if.sv
// Instruction-memory refill channel between fetch_cache_unit (master) and
// the instruction memory (slave). The request is held until memReady.
interface fetch_cache_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  memRequest;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic                  memReady;
  logic [DATA_WIDTH-1:0] memData;

  modport master (output memRequest, output memAddress, input memReady, input memData);
  modport slave  (input memRequest, input memAddress, output memReady, output memData);
endinterface

// File: rtl/fetch_cache_unit.sv
// Instruction fetch stage with a direct-mapped, one-word-per-line cache and
// a FETCH/MISS refill state machine. Redirects arriving during a refill are
// parked and applied when the refill completes.
// Optional feature macro: FETCH_STATS_EN (hit/miss statistics counters).
module fetch_cache_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LINES      = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  pcSource,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] fetchPc,
  output logic [ADDR_WIDTH-1:0] nextPc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  hit,
  output logic [31:0]           hitCount,
  output logic [31:0]           missCount,
  fetch_cache_unit_if.master    mem
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic {FETCH, MISS} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINES-1:0]      valid_q, valid_d;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [IDX_W-1:0]      idx, fill_idx;
  logic [TAG_W-1:0]      tag, fill_tag;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic                  fill;

  assign idx            = pc_q[IDX_W+1:2];
  assign tag            = pc_q[ADDR_WIDTH-1:IDX_W+2];
  assign fill_idx       = mem_addr_q[IDX_W+1:2];
  assign fill_tag       = mem_addr_q[ADDR_WIDTH-1:IDX_W+2];
  assign target_aligned = branchTarget & ~ADDR_WIDTH'(3);
  assign fill           = (state_q == MISS) && mem.memReady;

  assign hit         = (state_q == FETCH) && valid_q[idx] && (tag_mem[idx] == tag);
  assign instruction = hit ? data_mem[idx] : '0;
  assign fetchPc     = pc_q;
  assign nextPc      = pc_q + ADDR_WIDTH'(4);
  assign mem.memRequest = mem_req_q;
  assign mem.memAddress = mem_addr_q;

  // Next-state logic for PC, refill FSM, pending redirect and valid bits.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    valid_d       = valid_q;
    case (state_q)
      FETCH: begin
        if (pcSource) begin
          pc_d = target_aligned;
        end else if (hit) begin
          if (!stall) pc_d = pc_q + ADDR_WIDTH'(4);
        end else begin
          state_d    = MISS;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      MISS: begin
        if (pcSource) begin
          pend_valid_d  = 1'b1;
          pend_target_d = target_aligned;
        end
        if (mem.memReady) begin
          state_d           = FETCH;
          mem_req_d         = 1'b0;
          valid_d[fill_idx] = 1'b1;
          // A redirect in this very cycle beats an older parked one.
          if (pcSource)          pc_d = target_aligned;
          else if (pend_valid_q) pc_d = pend_target_q;
          pend_valid_d = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State and registered outputs; async reset abandons any refill in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      valid_q       <= valid_d;
    end
  end

  // Line storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem.memData;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, (hit && !stall)};
    miss_cnt_d = miss_cnt_q + {31'd0, ((state_q == FETCH) && !pcSource && !hit)};
  end

  // Statistics registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`else
  assign hitCount  = '0;
  assign missCount = '0;
`endif
endmodule

// File: tb/tb_fetch_cache_unit.sv
// Randomized bench for fetch_cache_unit with an address-level reference model:
// the cache is modelled as "which word address each line holds", and the
// instruction memory as a fixed function of the address.
module tb_fetch_cache_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] branchTarget = '0;
  logic        pcSource = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] fetchPc, nextPc, instruction, hitCount, missCount;
  logic        hit;

  int checks = 0;
  int errors = 0;

  fetch_cache_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

  fetch_cache_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINES(16), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .branchTarget(branchTarget), .pcSource(pcSource),
    .stall(stall), .fetchPc(fetchPc), .nextPc(nextPc), .instruction(instruction),
    .hit(hit), .hitCount(hitCount), .missCount(missCount), .mem(mem_if.master)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit          m_miss;
  logic [31:0] m_pc, m_maddr, m_pend_t;
  bit          m_pend_v;
  bit          m_valid [16];
  logic [31:0] m_line [16];
  logic [31:0] m_hits, m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ a;
  endfunction

  function automatic bit m_hit();
    int i;
    i = int'(m_pc[5:2]);
    return !m_miss && m_valid[i] && (m_line[i] == m_pc);
  endfunction

  task automatic model_reset();
    m_miss = 0; m_pc = 32'h0; m_maddr = 32'h0; m_pend_v = 0; m_pend_t = 32'h0;
    m_hits = 0; m_misses = 0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_line[i] = 32'h0; end
  endtask

  task automatic model_step(input bit pcs, input logic [31:0] tgt, input bit stl, input bit rdy);
    logic [31:0] t;
    bit h;
    t = {tgt[31:2], 2'b00};
    h = m_hit();
    if (!m_miss) begin
      if (h && !stl) m_hits = m_hits + 1;
      if (pcs) m_pc = t;
      else if (h) begin if (!stl) m_pc = m_pc + 32'd4; end
      else begin m_miss = 1; m_maddr = m_pc; m_misses = m_misses + 1; end
    end else begin
      if (pcs) begin m_pend_v = 1; m_pend_t = t; end
      if (rdy) begin
        m_valid[int'(m_maddr[5:2])] = 1;
        m_line[int'(m_maddr[5:2])] = m_maddr;
        m_miss = 0;
        if (m_pend_v) begin m_pc = m_pend_t; m_pend_v = 0; end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit h;
    h = m_hit();
    chk("fetchPc", fetchPc, m_pc);
    chk("nextPc", nextPc, m_pc + 32'd4);
    chk("hit", {31'd0, hit}, {31'd0, h});
    chk("instruction", instruction, h ? mem_word(m_pc) : 32'h0);
    chk("memRequest", {31'd0, mem_if.memRequest}, {31'd0, m_miss});
    chk("memAddress", mem_if.memAddress, m_maddr);
`ifdef FETCH_STATS_EN
    chk("hitCount", hitCount, m_hits);
    chk("missCount", missCount, m_misses);
`else
    chk("hitCount", hitCount, 32'h0);
    chk("missCount", missCount, 32'h0);
`endif
  endtask

  // One clock cycle: check outputs at the negedge, apply inputs, advance model.
  task automatic cycle(input bit pcs, input logic [31:0] tgt, input bit stl, input bit rdy);
    compare_all();
    pcSource = pcs; branchTarget = tgt; stall = stl;
    mem_if.memReady = rdy;
    mem_if.memData = rdy ? mem_word(m_maddr) : $urandom;
    model_step(pcs, tgt, stl, rdy);
    @(posedge clock);
    @(negedge clock);
  endtask

  // Asynchronous reset mid-cycle; memRequest must drop before any edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_memRequest", {31'd0, mem_if.memRequest}, 32'h0);
    chk("rst_fetchPc", fetchPc, 32'h0);
    model_reset();
    pcSource = 0; stall = 0; mem_if.memReady = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    int r;
    mem_if.memReady = 1'b0;
    mem_if.memData = '0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // Cold start
    chk("cold_hit0", {31'd0, hit}, 32'h0);
    chk("cold_nextPc", nextPc, 32'h4);
    cycle(0, 0, 0, 0);
    chk("cold_memReq", {31'd0, mem_if.memRequest}, 32'h1);
    chk("cold_memAddr", mem_if.memAddress, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("cold_hit1", {31'd0, hit}, 32'h1);
    chk("cold_instr", instruction, 32'h2008_0005);
`ifdef FETCH_STATS_EN
    chk("cold_missCount", missCount, 32'd1);
`endif
    cycle(0, 0, 0, 0);
    chk("cold_pc4", fetchPc, 32'h4);
`ifdef FETCH_STATS_EN
    chk("cold_hitCount", hitCount, 32'd1);
`endif

    // Redirect while in MISS
    cycle(1, 32'h8, 0, 0);
    chk("redir_noreq", {31'd0, mem_if.memRequest}, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(1, 32'h103, 0, 0);
    chk("redir_memAddr", mem_if.memAddress, 32'h8);
    cycle(0, 0, 0, 1);
    chk("redir_pc", fetchPc, 32'h100);
    cycle(1, 32'h8, 0, 0);
    chk("redir_hit8", {31'd0, hit}, 32'h1);
    cycle(0, 0, 1, 0);
    chk("stall_hold", fetchPc, 32'h8);

    // Conflict eviction (0x48 and 0x8 share a line)
    cycle(1, 32'h48, 0, 0);
    chk("conf_miss48", {31'd0, hit}, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("conf_hit48", {31'd0, hit}, 32'h1);
    cycle(1, 32'h8, 0, 0);
    chk("conf_evict8", {31'd0, hit}, 32'h0);
    cycle(0, 0, 0, 0);
    chk("conf_memAddr", mem_if.memAddress, 32'h8);
    cycle(0, 0, 0, 1);

    // PC wrap
    cycle(1, 32'hFFFF_FFFE, 0, 0);
    chk("wrap_pc", fetchPc, 32'hFFFF_FFFC);
    chk("wrap_nextPc", nextPc, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("wrap_zero", fetchPc, 32'h0);

    // Reset mid-miss, then a formerly cached address must miss
    cycle(1, 32'h20, 0, 0);
    cycle(0, 0, 0, 0);
    do_reset();
    chk("rst_miss0", {31'd0, hit}, 32'h0);
    cycle(0, 0, 0, 1);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 12)      tgt = $urandom_range(0, 255);
      else if (r < 14) tgt = 32'hFFFF_FF00 + $urandom_range(0, 255);
      else             tgt = $urandom;
      if (m_miss && $urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 5) == 0, tgt, $urandom_range(0, 3) == 0,
            m_miss ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0));
    end
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_cache_unit.md
# fetch_cache_unit

- Parametrised instruction-fetch stage with an integrated direct-mapped, one-word-per-line instruction cache and a miss/refill state machine.
- Holds the PC and presents the instruction at that PC to decode, with a hit flag.
- Redirects on branch and stalls on request.
- On a miss, requests the word from instruction memory over a request/ready handshake.

## Interface

Parameters:
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- LINES, 16, cache lines; power of two, at least 2
- RESET_PC, 0, PC value after reset; word-aligned

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- branchTarget  in  ADDR_WIDTH  redirect address; bits [1:0] ignored and forced to 0
- pcSource  in  1  1 = redirect to branchTarget; 0 = sequential
- stall  in  1  holds the PC in FETCH
- fetchPc  out  ADDR_WIDTH  address of the presented instruction
- nextPc  out  ADDR_WIDTH  fetchPc + 4, modulo 2^ADDR_WIDTH
- instruction  out  DATA_WIDTH  cached word when hit, else 0
- hit  out  1  instruction is valid this cycle
- memRequest  out  1  refill request, registered
- memAddress  out  ADDR_WIDTH  refill address, registered, word-aligned
- memReady  in  1  memData valid; completes the request
- memData  in  DATA_WIDTH  refill word
- hitCount  out  32  statistics counter (see Configuration)
- missCount  out  32  statistics counter (see Configuration)

## Operation

Address fields:
- index = fetchPc[log2(LINES)+1 : 2]
- tag = fetchPc[ADDR_WIDTH-1 : log2(LINES)+2]
- Each line stores valid, tag and data.

Lookup:
- Combinational: hit = (state == FETCH) && valid[index] && tag match.

States:
- FETCH:
  - If pcSource = 1: PC <- branchTarget at the edge, regardless of hit or stall. No miss is started.
  - Else if hit and stall = 0: PC <- PC + 4.
  - Else if hit and stall = 1: PC is held.
  - Else (miss): go to MISS; memRequest <- 1 and memAddress <- PC, registered.
- MISS:
  - memRequest stays 1 and memAddress stays stable until memReady = 1.
  - pcSource = 1 in MISS sets pendingValid and pendingTarget <- branchTarget. A later redirect in MISS overwrites the earlier one.
  - memReady = 1 at an edge does all of the following at that edge:
    - writes the line: valid = 1, tag from memAddress, data = memData;
    - clears memRequest;
    - returns to FETCH;
    - if pendingValid: PC <- pendingTarget and pendingValid is cleared; otherwise PC is unchanged.
  - The orphaned refill is always completed and written into the cache.
- stall has no effect in MISS.
- Replacement: direct-mapped overwrite. Conflicting addresses evict each other.
- There is no invalidate input. Instruction memory is read-only for this block.

## Timing

Reset (asynchronous assertion) sets:
- PC = RESET_PC, state = FETCH
- all valid bits = 0, pendingValid = 0
- memRequest = 0, memAddress = 0
- hitCount = missCount = 0

As a consequence, after reset hit = 0, instruction = 0, fetchPc = RESET_PC and nextPc = RESET_PC + 4.

Reset during MISS:
- memRequest drops immediately, without waiting for a clock edge.
- Memory must tolerate the abandoned request.
- memReady arriving after reset is ignored.

Latencies:
- Hit latency: 0 cycles. instruction and hit are combinational from fetchPc.
- Miss detected in cycle N: memRequest = 1 from cycle N+1.
- memReady sampled at edge M: hit = 1 in cycle M+1 at the same PC, or the pending target is looked up in cycle M+1.
- Minimum miss penalty: 2 cycles (memReady = 1 in the first MISS cycle).
- Redirect in FETCH: fetchPc = branchTarget in the next cycle.

Boundaries:
- PC increment wraps from 2^ADDR_WIDTH - 4 to 0.
- Simultaneous pcSource and memReady in MISS: the new target wins; the line is still written.

## Configuration

FETCH_STATS_EN:
- Defined:
  - hitCount increments on each cycle with hit = 1 and stall = 0.
  - missCount increments on each FETCH to MISS transition.
  - Both wrap at 2^32.
- Undefined:
  - Counter logic is absent.
  - hitCount and missCount are tied to 0.

## Test plan

- Cold start (RESET_PC = 0): release reset; cycle 1 has hit = 0. Cycle 2 has memRequest = 1 and memAddress = 0. memReady with memData = 0x20080005 three cycles later. Next cycle: hit = 1, instruction = 0x20080005. Following edge: fetchPc = 0x4.
- Sequential hits: preload 0x0 to 0x3C, then run 16 cycles with stall = 0 -> hit = 1 every cycle and fetchPc steps by 4. With stall = 1 for 2 cycles, fetchPc holds.
- Conflict (LINES = 16): fill 0x0, redirect to 0x40 -> miss, refill. Redirect back to 0x0 -> miss again, memAddress = 0x0.
- Redirect in MISS: miss at 0x8, pcSource = 1 with branchTarget = 0x103 while waiting. memReady -> line 0x8 written, next cycle fetchPc = 0x100. A later return to 0x8 hits.
- Reset mid-miss: assert reset while memRequest = 1 -> memRequest = 0 before the next edge. After release, fetchPc = RESET_PC and a previously filled address misses.
- With FETCH_STATS_EN defined: cold start plus 4 hits -> missCount = 1, hitCount = 4. Without the macro, both read 0.
